// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder: packs LW/SW/R-type/BEQ requests into RV32I words and
// streams them into instruction memory, one registered write per accepted beat.
`default_nettype none

module riscv_instr_encoder #(
   parameter int AW    = 5,
   parameter int DEPTH = 32,
   parameter int BASE  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [1:0]    in_kind_i,
   input  logic [4:0]    in_rd_i,
   input  logic [4:0]    in_rs1_i,
   input  logic [4:0]    in_rs2_i,
   input  logic [2:0]    in_funct3_i,
   input  logic          in_funct7b5_i,
   input  logic [12:0]   in_imm_i,
   input  logic          in_last_i,
   output logic          imem_we_o,
   output logic [AW-1:0] imem_addr_o,
   output logic [31:0]   imem_wdata_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          full_o,
   output logic [AW:0]   count_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
   localparam logic [AW-1:0] BASE_W  = AW'(BASE);

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [AW:0]   count_q, count_d;
   logic          done_q, done_d;
   logic          full_q, full_d;
   logic          last_q, last_d;

   logic [AW+1:0] occupancy;
   logic          accept;
   logic [31:0]   enc;
   logic          unused_imm0;

   assign unused_imm0 = in_imm_i[0];

   // Words accepted so far: committed writes plus the one still on the bus.
   assign occupancy  = {1'b0, count_q} + (AW+2)'(we_q);
   assign in_ready_o = (state_q == S_LOAD) && (occupancy < DEPTH_W);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      enc = 32'h0;
      case (in_kind_i)
         2'b00: enc = {in_imm_i[11:0], in_rs1_i, 3'b010, in_rd_i, 7'b0000011};
         2'b01: enc = {in_imm_i[11:5], in_rs2_i, in_rs1_i, 3'b010, in_imm_i[4:0], 7'b0100011};
         2'b10: enc = {1'b0, in_funct7b5_i, 5'b00000, in_rs2_i, in_rs1_i, in_funct3_i,
                       in_rd_i, 7'b0110011};
         2'b11: enc = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, 3'b000,
                       in_imm_i[4:1], in_imm_i[11], 7'b1100011};
         default: enc = 32'h0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      count_d = count_q + (AW+1)'(we_q);
      done_d  = done_q;
      full_d  = full_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_LOAD;
               count_d = '0;
               ptr_d   = BASE_W;
               done_d  = 1'b0;
               full_d  = 1'b0;
               last_d  = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = enc;
               ptr_d   = ptr_q + 1'b1;
               last_d  = in_last_i;
               if (in_last_i || (occupancy + 1'b1 == DEPTH_W)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // The final write is on the bus this cycle; the session closes behind it.
            state_d = S_DONE;
            done_d  = 1'b1;
            full_d  = ~last_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= BASE_W;
         ptr_q   <= BASE_W;
         wdata_q <= 32'h0;
         count_q <= '0;
         done_q  <= 1'b0;
         full_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         done_q  <= done_d;
         full_q  <= full_d;
         last_q  <= last_d;
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign busy_o       = (state_q == S_LOAD) || we_q;
   assign done_o       = done_q;
   assign full_o       = full_q;
   assign count_o      = count_q;

endmodule

`default_nettype wire
